// File: rtl/vspu_pkg.sv
// Shared definitions for the vector scalar pack unit: firmware mode
// encodings and the helper that sizes counters and chain selects.
package vspu_pkg;

   localparam logic [7:0] MODE_PASS = 8'd0;
   localparam logic [7:0] MODE_PACK = 8'd1;

   // Width needed to index 'value' entries; never narrower than one bit
   function automatic int count_width(input int value);
      return (value <= 1) ? 1 : $clog2(value);
   endfunction

endpackage

// File: rtl/pack_lane_buffer.sv
// One chain's packing buffer: collects scalars lane by lane and presents
// the vector that would be emitted this cycle, i.e. the stored lanes plus
// the incoming scalar, with every lane past the fill level forced to zero.
module pack_lane_buffer
   import vspu_pkg::*;
#(
   parameter int N          = 8,
   parameter int DATA_WIDTH = 32,
   parameter int CNT_W      = count_width(N)
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           write,
   input  logic                           flush,
   input  logic                           clear,
   input  logic [DATA_WIDTH-1:0]          scalar,
   output logic [CNT_W-1:0]               cnt,
   output logic [N-1:0][DATA_WIDTH-1:0]   packed_data
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

   logic [N-1:0][DATA_WIDTH-1:0] lane_store;

   // Fill level and storage; a write that completes the vector or arrives
   // with a flush is emitted straight from the input, so it is not stored
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt        <= '0;
         lane_store <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (write) begin
         if (flush || cnt == LAST) begin
            cnt <= '0;
         end else begin
            lane_store[cnt] <= scalar;
            cnt             <= cnt + 1'b1;
         end
      end else if (flush) begin
         cnt <= '0;
      end
   end

   // Candidate output vector: stored lanes, then the new scalar, then zeros
   always_comb begin
      packed_data = '0;
      for (int i = 0; i < N; i++) begin
         if (i < int'(cnt)) begin
            packed_data[i] = lane_store[i];
         end else if (write && i == int'(cnt)) begin
            packed_data[i] = scalar;
         end
      end
   end

endmodule

// File: rtl/vector_scalar_pack_unit.sv
// Vector scalar pack unit: per chain, either passes reduced vectors through
// or packs the lane-0 scalars of successive inputs into full vectors.
// Define PACK_LANE_MASK_EN to add the lane_valid_out per-lane qualifier.
module vector_scalar_pack_unit
   import vspu_pkg::*;
#(
   parameter int         N                  = 8,
   parameter int         DATA_WIDTH         = 32,
   parameter int         MAX_CHAINS         = 4,
   parameter int         PERSONAL_CONFIG_ID = 0,
   parameter logic [7:0] INITIAL_FIRMWARE [0:MAX_CHAINS-1] = '{default: 8'd0},
   localparam int        CW                 = count_width(MAX_CHAINS)
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           valid_in,
   input  logic                           eof_in,
   input  logic [CW-1:0]                  chainId_in,
   input  logic                           tracing,
   input  logic [7:0]                     configId,
   input  logic [7:0]                     configData,
   input  logic [N-1:0][DATA_WIDTH-1:0]   vector_in,
   output logic                           valid_out,
   output logic                           eof_out,
   output logic [CW-1:0]                  chainId_out,
`ifdef PACK_LANE_MASK_EN
   output logic [N-1:0]                   lane_valid_out,
`endif
   output logic [N-1:0][DATA_WIDTH-1:0]   vector_out
);

   localparam int CNT_W = count_width(N);

   logic [7:0]                   firmware [MAX_CHAINS];
   logic [MAX_CHAINS-1:0]        chain_write;
   logic [MAX_CHAINS-1:0]        chain_flush;
   logic [MAX_CHAINS-1:0]        chain_clear;
   logic [CNT_W-1:0]             chain_cnt  [MAX_CHAINS];
   logic [N-1:0][DATA_WIDTH-1:0] chain_data [MAX_CHAINS];

   logic                         cfg_hit;
   int                           cfg_slot;
   logic                         sel_pack;
   logic [CNT_W-1:0]             sel_cnt;
   logic [N-1:0][DATA_WIDTH-1:0] sel_data;
   logic                         sel_full;
   logic                         sel_empty;
   logic                         pass_emit;
   logic                         pack_emit;

   for (genvar c = 0; c < MAX_CHAINS; c++) begin : g_chain
      pack_lane_buffer #(
         .N          (N),
         .DATA_WIDTH (DATA_WIDTH),
         .CNT_W      (CNT_W)
      ) u_buffer (
         .clk         (clk),
         .rst_n       (rst_n),
         .write       (chain_write[c]),
         .flush       (chain_flush[c]),
         .clear       (chain_clear[c]),
         .scalar      (vector_in[0]),
         .cnt         (chain_cnt[c]),
         .packed_data (chain_data[c])
      );
   end

   // Decode config writes and route the current input to its chain buffer
   always_comb begin
      cfg_hit     = !tracing
                    && int'(configId) >= PERSONAL_CONFIG_ID
                    && int'(configId) <  PERSONAL_CONFIG_ID + MAX_CHAINS;
      cfg_slot    = int'(configId) - PERSONAL_CONFIG_ID;
      sel_pack    = 1'b0;
      sel_cnt     = '0;
      sel_data    = '0;
      chain_write = '0;
      chain_flush = '0;
      chain_clear = '0;
      for (int c = 0; c < MAX_CHAINS; c++) begin
         if (int'(chainId_in) == c) begin
            sel_pack       = (firmware[c] == MODE_PACK);
            sel_cnt        = chain_cnt[c];
            sel_data       = chain_data[c];
            chain_write[c] = tracing && valid_in && (firmware[c] == MODE_PACK);
            chain_flush[c] = tracing && eof_in   && (firmware[c] == MODE_PACK);
         end
         if (cfg_hit && cfg_slot == c) begin
            chain_clear[c] = 1'b1;
         end
      end
   end

   assign sel_full  = (sel_cnt == CNT_W'(N - 1));
   assign sel_empty = (sel_cnt == '0);
   assign pass_emit = tracing && !sel_pack && valid_in;
   assign pack_emit = tracing && sel_pack
                      && ((valid_in && sel_full) || (eof_in && (valid_in || !sel_empty)));

   // Per-chain firmware mode, rewritten by config cycles in this unit's window
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < MAX_CHAINS; c++) begin
            firmware[c] <= INITIAL_FIRMWARE[c];
         end
      end else begin
         for (int c = 0; c < MAX_CHAINS; c++) begin
            if (cfg_hit && cfg_slot == c) begin
               firmware[c] <= configData;
            end
         end
      end
   end

   // Output register; vector_out holds its last value while nothing is emitted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_out   <= 1'b0;
         eof_out     <= 1'b0;
         chainId_out <= '0;
         vector_out  <= '0;
      end else begin
         valid_out   <= pass_emit || pack_emit;
         eof_out     <= eof_in;
         chainId_out <= chainId_in;
         if (pass_emit) begin
            vector_out <= vector_in;
         end else if (pack_emit) begin
            vector_out <= sel_data;
         end
      end
   end

`ifdef PACK_LANE_MASK_EN
   logic [N-1:0] pack_mask;

   // Lanes carrying data in a pack emission: stored lanes plus the new scalar
   always_comb begin
      pack_mask = '0;
      for (int i = 0; i < N; i++) begin
         pack_mask[i] = (i < int'(sel_cnt)) || (valid_in && i == int'(sel_cnt));
      end
   end

   // Lane qualifier registered alongside vector_out
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lane_valid_out <= '0;
      end else if (pass_emit) begin
         lane_valid_out <= '1;
      end else if (pack_emit) begin
         lane_valid_out <= pack_mask;
      end else begin
         lane_valid_out <= '0;
      end
   end
`else
   // Without the lane mask the emitted vector alone carries the result
`endif

endmodule

// File: tb/tb_vector_scalar_pack_unit.sv
// Testbench for vector_scalar_pack_unit: directed steps with a reference
// model that pushes expected emissions onto a scoreboard queue.
// Define PACK_LANE_MASK_EN to also check lane_valid_out.
module tb_vector_scalar_pack_unit;

   localparam int N  = 8;
   localparam int DW = 32;
   localparam int MC = 4;
   localparam int CW = 2;

   typedef logic [N-1:0][DW-1:0] vec_t;
   typedef struct packed {
      vec_t          data;
      logic [N-1:0]  mask;
      logic [CW-1:0] chain;
      logic          eof;
   } exp_t;

   logic          clk;
   logic          rst_n;
   logic          valid_in;
   logic          eof_in;
   logic [CW-1:0] chainId_in;
   logic          tracing;
   logic [7:0]    configId;
   logic [7:0]    configData;
   vec_t          vector_in;
   logic          valid_out;
   logic          eof_out;
   logic [CW-1:0] chainId_out;
   vec_t          vector_out;
`ifdef PACK_LANE_MASK_EN
   logic [N-1:0]  lane_valid_out;
`endif

   exp_t          sb [$];
   int            checks = 0;
   int            errors = 0;
   logic [7:0]    m_fw  [MC];
   int            m_cnt [MC];
   logic [DW-1:0] m_buf [MC][N];
   logic [CW-1:0] last_chain;
   logic          last_eof;

   vector_scalar_pack_unit #(
      .N                  (N),
      .DATA_WIDTH         (DW),
      .MAX_CHAINS         (MC),
      .PERSONAL_CONFIG_ID (0),
      .INITIAL_FIRMWARE   ('{8'd0, 8'd1, 8'd0, 8'd0})
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .valid_in       (valid_in),
      .eof_in         (eof_in),
      .chainId_in     (chainId_in),
      .tracing        (tracing),
      .configId       (configId),
      .configData     (configData),
      .vector_in      (vector_in),
      .valid_out      (valid_out),
      .eof_out        (eof_out),
      .chainId_out    (chainId_out),
`ifdef PACK_LANE_MASK_EN
      .lane_valid_out (lane_valid_out),
`endif
      .vector_out     (vector_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t scal(input logic [DW-1:0] s);
      vec_t v;
      v      = '0;
      v[0]   = s;
      v[N-1] = 32'hDEAD_BEEF;
      return v;
   endfunction

   function automatic vec_t ramp(input logic [DW-1:0] base);
      vec_t v;
      for (int i = 0; i < N; i++) v[i] = base + DW'(i);
      return v;
   endfunction

   task automatic compare(input string tag, input logic [N*DW-1:0] obs, input logic [N*DW-1:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic model_reset();
      m_fw[0] = 8'd0; m_fw[1] = 8'd1; m_fw[2] = 8'd0; m_fw[3] = 8'd0;
      for (int c = 0; c < MC; c++) m_cnt[c] = 0;
      sb.delete();
   endtask

   task automatic check_output();
      exp_t x;
      compare("eof_out", eof_out, last_eof);
      compare("chainId_out", chainId_out, last_chain);
      if (sb.size() > 0) begin
         x = sb.pop_front();
         compare("valid_out_high", valid_out, 1'b1);
         compare("vector_out", vector_out, x.data);
         compare("emit_chain", chainId_out, x.chain);
`ifdef PACK_LANE_MASK_EN
         compare("lane_valid_out", lane_valid_out, x.mask);
`endif
      end else begin
         compare("valid_out_low", valid_out, 1'b0);
`ifdef PACK_LANE_MASK_EN
         compare("lane_valid_idle", lane_valid_out, '0);
`endif
      end
   endtask

   task automatic apply_stimulus(input logic tr, input logic v, input logic e, input logic [CW-1:0] ch,
                                 input vec_t d, input logic [7:0] cid, input logic [7:0] cdat);
      exp_t x;
      tracing = tr; valid_in = v; eof_in = e; chainId_in = ch;
      vector_in = d; configId = cid; configData = cdat;
      if (tr) begin
         if (m_fw[ch] == 8'd1) begin
            if (v) begin
               m_buf[ch][3'(m_cnt[ch])] = d[0];
               m_cnt[ch]++;
            end
            if ((v && m_cnt[ch] == N) || (e && m_cnt[ch] > 0)) begin
               x.data = '0; x.mask = '0;
               for (int i = 0; i < m_cnt[ch]; i++) begin
                  x.data[i] = m_buf[ch][i];
                  x.mask[i] = 1'b1;
               end
               x.chain = ch; x.eof = e;
               sb.push_back(x);
               m_cnt[ch] = 0;
            end
         end else if (v) begin
            x.data = d; x.mask = '1; x.chain = ch; x.eof = e;
            sb.push_back(x);
         end
      end else if (int'(cid) < MC) begin
         m_fw[cid[1:0]]  = cdat;
         m_cnt[cid[1:0]] = 0;
      end
      last_chain = ch;
      last_eof   = e;
      @(posedge clk);
      #1;
      check_output();
   endtask

   task automatic idle_inputs();
      tracing = 1'b1; valid_in = 1'b0; eof_in = 1'b0; chainId_in = '0;
      vector_in = '0; configId = 8'd0; configData = 8'd0;
   endtask

   task automatic mid_cycle_reset();
      #4;
      rst_n = 1'b0;
      #1;
      compare("rst_valid_out", valid_out, 1'b0);
      compare("rst_eof_out", eof_out, 1'b0);
      compare("rst_chainId_out", chainId_out, '0);
      compare("rst_vector_out", vector_out, '0);
      idle_inputs();
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      last_chain = '0;
      last_eof   = 1'b0;
      @(posedge clk);
      #1;
      check_output();
   endtask

   initial begin
      rst_n = 1'b0;
      idle_inputs();
      model_reset();
      #12;
      compare("init_valid_out", valid_out, 1'b0);
      compare("init_eof_out", eof_out, 1'b0);
      compare("init_vector_out", vector_out, '0);
      @(negedge clk);
      rst_n = 1'b1;
      last_chain = '0;
      last_eof   = 1'b0;
      @(posedge clk);
      #1;
      check_output();

      $display("[TB] chain 0 pass-through");
      apply_stimulus(1, 1, 0, 2'd0, ramp(32'd1), 8'd0, 8'd0);

      $display("[TB] configure chain 0 as pack, valid data ignored in config mode");
      apply_stimulus(0, 1, 0, 2'd0, ramp(32'd50), 8'd0, 8'd1);
      for (int i = 0; i < N; i++) apply_stimulus(1, 1, 0, 2'd0, scal(32'd10 + 32'(i)), 8'd0, 8'd0);

      $display("[TB] chain 1 partial flush");
      apply_stimulus(1, 1, 0, 2'd1, scal(32'd5), 8'd0, 8'd0);
      apply_stimulus(1, 1, 0, 2'd1, scal(32'd6), 8'd0, 8'd0);
      apply_stimulus(1, 1, 1, 2'd1, scal(32'd7), 8'd0, 8'd0);
      apply_stimulus(1, 0, 1, 2'd1, '0, 8'd0, 8'd0);

      $display("[TB] interleaved chains 0 and 2, with discarded partial on chain 2");
      apply_stimulus(0, 0, 0, 2'd0, '0, 8'd2, 8'd1);
      apply_stimulus(1, 1, 0, 2'd2, scal(32'd99), 8'd0, 8'd0);
      apply_stimulus(1, 1, 0, 2'd2, scal(32'd98), 8'd0, 8'd0);
      apply_stimulus(0, 0, 0, 2'd0, '0, 8'd2, 8'd1);
      for (int i = 0; i < N; i++) begin
         apply_stimulus(1, 1, 0, 2'd0, scal(32'hA0 + 32'(i)), 8'd0, 8'd0);
         apply_stimulus(1, 1, 0, 2'd2, scal(32'hB0 + 32'(i)), 8'd0, 8'd0);
      end

      $display("[TB] out-of-window config and flush with scalar");
      for (int i = 0; i < 3; i++) apply_stimulus(1, 1, 0, 2'd0, scal(32'h31 + 32'(i)), 8'd0, 8'd0);
      apply_stimulus(0, 0, 0, 2'd0, '0, 8'd7, 8'd0);
      apply_stimulus(1, 1, 1, 2'd0, scal(32'h34), 8'd0, 8'd0);

      $display("[TB] unknown firmware value behaves as pass");
      apply_stimulus(0, 0, 0, 2'd0, '0, 8'd3, 8'd5);
      apply_stimulus(1, 1, 1, 2'd3, ramp(32'h70), 8'd0, 8'd0);

      $display("[TB] reset in the middle of a pack");
      for (int i = 0; i < 4; i++) apply_stimulus(1, 1, 0, 2'd1, scal(32'h60 + 32'(i)), 8'd0, 8'd0);
      apply_stimulus(1, 1, 0, 2'd3, ramp(32'h80), 8'd0, 8'd0);
      mid_cycle_reset();
      apply_stimulus(1, 1, 0, 2'd0, ramp(32'h90), 8'd0, 8'd0);
      for (int i = 0; i < N; i++) apply_stimulus(1, 1, 0, 2'd1, scal(32'h20 + 32'(i)), 8'd0, 8'd0);
      idle_inputs();
      last_chain = '0;
      last_eof   = 1'b0;
      @(posedge clk);
      #1;
      check_output();

      compare("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
